// File: rtl/sr_ff_checker.sv
// Reference-model response checker for an sr_ff instance: tracks expected q and
// flags q/qb mismatches and illegal S=R=1 inputs. Define SR_TOGGLE_EN to treat S=R=1 as a JK toggle.
module sr_ff_checker #(
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 s,
   input  logic                 r,
   input  logic                 q,
   input  logic                 qb,
   input  logic                 clr_err,
   output logic                 synced,
   output logic                 mismatch,
   output logic                 illegal,
   output logic                 fail,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   typedef enum logic {
      ST_UNSYNC = 1'b0,
      ST_TRACK  = 1'b1
   } state_e;

   localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

   state_e               state_q, state_d;
   logic                 exp_val_q, exp_val_d;
   logic                 mismatch_q, mismatch_d;
   logic                 illegal_q, illegal_d;
   logic                 fail_q, fail_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_UNSYNC;
         exp_val_q  <= 1'b0;
         mismatch_q <= 1'b0;
         illegal_q  <= 1'b0;
         fail_q     <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         exp_val_q  <= exp_val_d;
         mismatch_q <= mismatch_d;
         illegal_q  <= illegal_d;
         fail_q     <= fail_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   // q is compared against the expectation formed one edge earlier; qb must always be ~q
   always_comb begin
      state_d    = state_q;
      exp_val_d  = exp_val_q;
      mismatch_d = 1'b0;
      illegal_d  = 1'b0;
      fail_d     = fail_q;
      err_cnt_d  = err_cnt_q;

      if (en) begin
         mismatch_d = ((state_q == ST_TRACK) && (q != exp_val_q)) || (qb == q);
         unique case ({s, r})
            2'b10: begin
               exp_val_d = 1'b1;
               state_d   = ST_TRACK;
            end
            2'b01: begin
               exp_val_d = 1'b0;
               state_d   = ST_TRACK;
            end
            2'b11: begin
`ifdef SR_TOGGLE_EN
               if (state_q == ST_TRACK) begin
                  exp_val_d = ~exp_val_q;
               end
`else
               illegal_d = 1'b1;
               state_d   = ST_UNSYNC;
`endif
            end
            default: ;
         endcase
      end

      // Clear wins over a same-edge mismatch, which still pulses but is not recorded
      if (clr_err) begin
         fail_d    = 1'b0;
         err_cnt_d = '0;
      end else if (mismatch_d) begin
         fail_d = 1'b1;
         if (err_cnt_q != CNT_MAX) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
         end
      end
   end

   assign synced   = (state_q == ST_TRACK);
   assign mismatch = mismatch_q;
   assign illegal  = illegal_q;
   assign fail     = fail_q;
   assign err_cnt  = err_cnt_q;

endmodule
